// File: rtl/instruction_fetch_queue.sv
// ----------------------------------------------------------------------------
// instruction_fetch_queue
//
// Fetch unit with a prefetch FIFO between a synchronous instruction memory
// (one-cycle read latency) and decode. A word-addressed fetch PC issues at most
// one read per cycle. Each returned word is queued with its PC. A redirect
// flushes the queue and drops the read that is still in flight.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   fetch_en       allow new memory reads (an outstanding read still lands)
//   redirect_en    one-cycle pulse: jump to redirect_addr, flush the queue
//   redirect_addr  redirect target (word address)
//   imem_rd_en     memory read strobe
//   imem_addr      byte address {fetch_pc, 2'b00}
//   imem_rdata     read data, valid the cycle after imem_rd_en
//   inst_valid     queue head is valid
//   inst_ready     decode accepts the head entry
//   inst_data      instruction at the queue head (holds when empty)
//   inst_pc        word address of the queue head (holds when empty)
//   queue_count    current queue occupancy
// ----------------------------------------------------------------------------
module instruction_fetch_queue #(
  parameter int unsigned        ADDR_W      = 30,
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fetch_en,
  input  logic                          redirect_en,
  input  logic [ADDR_W-1:0]             redirect_addr,
  output logic                          imem_rd_en,
  output logic [ADDR_W+1:0]             imem_addr,
  input  logic [DATA_W-1:0]             imem_rdata,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [DATA_W-1:0]             inst_data,
  output logic [ADDR_W-1:0]             inst_pc,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;

  logic [DATA_W-1:0] data_mem [QUEUE_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [QUEUE_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  // Last value shown on the head outputs, replayed while the queue is empty.
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_pc;

  logic space_free;
  logic push;
  logic pop;

  // A queue slot is reserved at issue time, so the in-flight read counts as
  // occupied. This keeps every later push from overflowing.
  assign space_free = ({1'b0, count} + {{CNT_W{1'b0}}, inflight})
                      < (CNT_W + 1)'(QUEUE_DEPTH);

  assign imem_rd_en = fetch_en & ~redirect_en & ~reset & space_free;
  assign imem_addr  = {fetch_pc, 2'b00};

  // Redirect outranks capture and pop. The returning word is dropped, and the
  // head is not consumed even when decode is ready.
  assign push = inflight & ~redirect_en;
  assign pop  = inst_valid & inst_ready & ~redirect_en;

  assign inst_valid  = (count != '0);
  assign inst_data   = inst_valid ? data_mem[rd_ptr] : hold_data;
  assign inst_pc     = inst_valid ? pc_mem[rd_ptr]   : hold_pc;
  assign queue_count = count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      hold_data   <= '0;
      hold_pc     <= '0;
    end else begin
      hold_data <= inst_data;
      hold_pc   <= inst_pc;
      if (redirect_en) begin
        fetch_pc <= redirect_addr;
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= imem_rd_en;
        if (imem_rd_en) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + ADDR_W'(1);
        end
        // Depth is a power of two, so the pointers wrap on natural overflow.
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset. Entries are only read while count says
  // they are valid, and leaving the reset off keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_queue
//
// The bench holds a behavioural model of the fetch queue. An expected-entry
// queue gets an entry whenever a read returns, and that entry is removed on
// each accepted handshake. A separate monitor compares the DUT with the model
// every cycle. Stimulus is a set of directed scenarios followed by a long
// randomised run.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_queue;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [ADDR_W-1:0] PC_MAX   = '1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_en = 1'b0;
  logic              redirect_en = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              imem_rd_en;
  logic [ADDR_W+1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b1;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [CNT_W-1:0]  queue_count;

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;

  // Reference model state
  entry_t            exp_q[$];
  entry_t            m_last;
  logic [ADDR_W-1:0] m_fetch_pc;
  logic [ADDR_W-1:0] m_inflight_pc;
  bit                m_inflight;
  bit                model_ok = 1'b0;

  instruction_fetch_queue #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .queue_count   (queue_count)
  );

  always #5 clk = ~clk;

  // Memory contents are a hash of the word address, so data and pc differ.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] t;
    t = {2'b00, a} * 32'h9E37_79B1;
    return t ^ 32'h0F1E_2D3C;
  endfunction

  // Synchronous instruction memory with one-cycle read latency
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem_word(imem_addr[ADDR_W+1:2]);
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model update, applied at each rising edge from the inputs seen in that cycle
  task automatic model_step();
    entry_t shown;
    bit     issue;
    if (reset) begin
      m_fetch_pc = RESET_PC;
      m_inflight = 1'b0;
      exp_q.delete();
      m_last     = '0;
      model_ok   = 1'b1;
      return;
    end
    if (!model_ok) return;
    shown  = (exp_q.size() != 0) ? exp_q[0] : m_last;
    m_last = shown;
    if (redirect_en) begin
      m_fetch_pc = redirect_addr;
      m_inflight = 1'b0;
      exp_q.delete();
      return;
    end
    issue = fetch_en && (exp_q.size() + int'(m_inflight) < DEPTH);
    if (exp_q.size() != 0 && inst_ready) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (m_inflight) exp_q.push_back({m_inflight_pc, mem_word(m_inflight_pc)});
    if (issue) begin
      m_inflight_pc = m_fetch_pc;
      m_fetch_pc    = m_fetch_pc + ADDR_W'(1);
      m_inflight    = 1'b1;
    end else begin
      m_inflight = 1'b0;
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares the DUT outputs with the model, away from the edge
  initial begin : monitor_proc
    bit     exp_rd;
    entry_t exp_head;
    forever begin
      @(negedge clk);
      #2;
      if (model_ok) begin
        exp_rd   = !reset && fetch_en && !redirect_en
                   && (exp_q.size() + int'(m_inflight) < DEPTH);
        exp_head = (exp_q.size() != 0) ? exp_q[0] : m_last;
        check("imem_rd_en",  64'(imem_rd_en),  64'(exp_rd));
        check("imem_addr",   64'(imem_addr),   64'({m_fetch_pc, 2'b00}));
        check("queue_count", 64'(queue_count), 64'(exp_q.size()));
        check("inst_valid",  64'(inst_valid),  64'(exp_q.size() != 0));
        check("inst_pc",     64'(inst_pc),     64'(exp_head.pc));
        check("inst_data",   64'(inst_data),   64'(exp_head.data));
      end
    end
  end

  task automatic cyc(input bit rst, input bit fen, input bit rdr,
                     input logic [ADDR_W-1:0] ra, input bit rdy);
    @(negedge clk);
    reset         = rst;
    fetch_en      = fen;
    redirect_en   = rdr;
    redirect_addr = ra;
    inst_ready    = rdy;
  endtask

  initial begin : driver_proc
    logic [ADDR_W-1:0] ra;
    // Reset, then free-run
    repeat (2)  cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    repeat (12) cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    // Backpressure until full, then drain
    repeat (8)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    repeat (8)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    // Redirect with entries queued and a read in flight
    repeat (2)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, ADDR_W'('h100), 1'b0);
    repeat (8)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    // Redirect on a full queue while decode is ready
    repeat (8)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, ADDR_W'('h200), 1'b1);
    repeat (6)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    // PC wrap-around
    cyc(1'b0, 1'b1, 1'b1, PC_MAX - ADDR_W'(1), 1'b1);
    repeat (8)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    // fetch_en low for three cycles
    repeat (3)  cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (6)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    // Reset with entries queued
    repeat (3)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
    repeat (6)  cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    // Randomised run
    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? PC_MAX - ADDR_W'($urandom_range(0, 3))
                                       : ADDR_W'($urandom());
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 19) == 0),
          ra,
          ($urandom_range(0, 9) < 6));
    end
    @(negedge clk);
    #3;
    check("delivered_min", 64'(delivered >= 300), 64'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
